trace_readback_sequencer: RTL and testbench
===========================================

TRACE_READBACK_SEQUENCER -- requirements
Module: trace_readback_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of sample-number ports.
REQ-002 SHALL have parameter DEPTH, default 2**25, ring capacity in sample packets; legal addresses 0..DEPTH-1.
REQ-003 SHALL have parameter BURST, default 4, packets per read request; BURST >= 1; DEPTH a multiple of BURST.
REQ-004 SHALL have parameter CNT_W, default 24, width of req_count.
REQ-005 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  readback request.
REQ-008 SHALL have port capture_idle  in  1  sampler is idle.
REQ-009 SHALL have port win_begin  in  ADDR_W  first packet of window.
REQ-010 SHALL have port win_end  in  ADDR_W  one past last packet of window (ring position).
REQ-011 SHALL have port rd_req  out  1  read request valid.
REQ-012 SHALL have port rd_addr  out  ADDR_W  packet address of request.
REQ-013 SHALL have port rd_last  out  1  current request is final of window.
REQ-014 SHALL have port rd_ready  in  1  consumer accepts request.
REQ-015 SHALL have port busy  out  1  readback in progress.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port req_count  out  CNT_W  requests accepted in current/last readback.
REQ-018 SHALL have port abort  in  1  stop readback; present only with READBACK_ABORT_EN.

Function
REQ-019 SHALL implement states IDLE, READING, DONE.
REQ-020 IDLE -> READING SHALL occur when start & capture_idle; start otherwise ignored, including while busy.
REQ-021 On start SHALL latch cur = win_begin, req_count = 0, remaining = (win_end - win_begin) mod DEPTH, with remaining = DEPTH when win_begin == win_end.
REQ-022 READING: rd_req = 1, rd_addr = cur, rd_last = (remaining <= BURST), busy = 1.
REQ-023 Transfer = rd_req & rd_ready; rd_req, rd_addr, rd_last SHALL hold stable until transfer.
REQ-024 On transfer: cur <= cur+BURST, minus DEPTH if result >= DEPTH; remaining <= remaining-BURST (saturate 0); req_count += 1 (wraps at 2**CNT_W).
REQ-025 Transfer with rd_last = 1 SHALL move to DONE; DONE lasts exactly one cycle with done = 1, busy = 1, rd_req = 0, then IDLE.
REQ-026 Remaining not a multiple of BURST SHALL round up: final request still issued, BURST packets.
REQ-027 win_begin/win_end changes after start SHALL have no effect; win_begin >= DEPTH is undefined.
REQ-028 IDLE: rd_req = 0, rd_last = 0, busy = 0, done = 0, rd_addr = last cur, req_count holds.

Reset
REQ-029 reset SHALL force IDLE, rd_req = 0, rd_last = 0, busy = 0, done = 0, rd_addr = 0, req_count = 0, remaining = 0.
REQ-030 reset mid-READING SHALL drop rd_req next cycle without done pulse; reset dominates start and abort.

Configuration
REQ-031 Macro READBACK_ABORT_EN SHALL enable port abort: abort in READING SHALL go to DONE next cycle (done pulses, transfer in that same cycle still counted); abort in IDLE/DONE ignored.
REQ-032 Without READBACK_ABORT_EN port abort SHALL not exist; readback ends only via rd_last transfer or reset.

Structure
REQ-033 State encoding enum and wrap-add helper SHALL live in shared package analyzer_pkg.
REQ-034 Ring address increment SHALL be sub-module ring_addr_step (cur, BURST, DEPTH -> next), reused by capture path.

Verification
REQ-035 DEPTH=64, BURST=4, begin=8, end=24, rd_ready=1 -> addrs 8,12,16,20; rd_last on 20; done one cycle later; req_count=4.
REQ-036 begin=56, end=8 -> addrs 56,60,0,4; wrap with no skipped/duplicated address; req_count=4.
REQ-037 begin=end=16 -> 16 requests, 16..60 then 0..12, rd_last on 12.
REQ-038 rd_ready toggled 1,0,0,1 -> rd_addr/rd_last stable across stall; req_count counts only accepted.
REQ-039 start with capture_idle=0 -> stays IDLE; reset asserted after 2nd transfer -> rd_req=0 next cycle, no done, req_count=0.
REQ-040 With READBACK_ABORT_EN: abort after 1st transfer of 8..24 window -> done pulse next cycle, req_count=1, rd_req low after.

Source files
------------

// File: rtl/analyzer_pkg.sv
// rtl/analyzer_pkg.sv - shared readback/capture state encoding and ring wrap-add helper
package analyzer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READING = 2'd1,
        ST_DONE    = 2'd2
    } rb_state_t;

    // Operands are assumed already inside the ring, so one conditional subtract suffices.
    function automatic logic [63:0] wrap_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [63:0] depth);
        logic [63:0] sum;
        sum = a + b;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage

// File: rtl/ring_addr_step.sv
// rtl/ring_addr_step.sv - advance a ring packet address by BURST, wrapping at DEPTH
module ring_addr_step
    import analyzer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2**25,
    parameter int BURST  = 4
) (
    input  logic [ADDR_W-1:0] cur,
    output logic [ADDR_W-1:0] next
);

    assign next = ADDR_W'(wrap_add(64'(cur), 64'(BURST), 64'(DEPTH)));

endmodule

// File: rtl/trace_readback_sequencer.sv
// rtl/trace_readback_sequencer.sv - walks a trace window in BURST-packet read requests; READBACK_ABORT_EN adds abort
module trace_readback_sequencer
    import analyzer_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2**25,
    parameter int BURST  = 4,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              capture_idle,
    input  logic [ADDR_W-1:0] win_begin,
    input  logic [ADDR_W-1:0] win_end,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    input  logic              rd_ready,
`ifdef READBACK_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  req_count
);

    localparam logic [ADDR_W:0] BURST_R = (ADDR_W+1)'(BURST);

    rb_state_t         state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] cur_next;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   rem_next;
    logic [ADDR_W:0]   rem_init;
    logic [63:0]       span;
    logic              xfer;
    logic              abort_req;

    ring_addr_step #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BURST  (BURST)
    ) u_step (
        .cur  (cur),
        .next (cur_next)
    );

    // Window length modulo ring size; an empty span means the whole ring.
    always_comb begin
        span     = wrap_add(64'(win_end), 64'(DEPTH) - 64'(win_begin), 64'(DEPTH));
        rem_init = (span == 64'd0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(span);
    end

    assign rem_next = (remaining > BURST_R) ? (remaining - BURST_R) : '0;
    assign xfer     = rd_req & rd_ready;

`ifdef READBACK_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur       <= '0;
            remaining <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            req_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start && capture_idle) begin
                        state     <= ST_READING;
                        cur       <= win_begin;
                        rd_addr   <= win_begin;
                        remaining <= rem_init;
                        rd_last   <= (rem_init <= BURST_R);
                        rd_req    <= 1'b1;
                        busy      <= 1'b1;
                        req_count <= '0;
                    end
                end
                ST_READING: begin
                    if (xfer) begin
                        cur       <= cur_next;
                        remaining <= rem_next;
                        req_count <= req_count + CNT_W'(1);
                    end
                    // An abort still counts a transfer accepted in the same cycle.
                    if ((xfer && rd_last) || abort_req) begin
                        state   <= ST_DONE;
                        rd_req  <= 1'b0;
                        rd_last <= 1'b0;
                        done    <= 1'b1;
                    end else if (xfer) begin
                        rd_addr <= cur_next;
                        rd_last <= (rem_next <= BURST_R);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_readback_sequencer.sv
// tb/tb_trace_readback_sequencer.sv - scoreboard bench for trace_readback_sequencer (abort cases under READBACK_ABORT_EN)
module tb_trace_readback_sequencer;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;
    localparam int BURST  = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              capture_idle;
    logic [ADDR_W-1:0] win_begin;
    logic [ADDR_W-1:0] win_end;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;
    logic              rd_ready;
`ifdef READBACK_ABORT_EN
    logic              abort;
`endif
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  req_count;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [8:0]        exp_q[$];
    logic [8:0]        exp_e;
    bit                chk_hold   = 1'b1;
    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_last;

    trace_readback_sequencer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BURST  (BURST),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .capture_idle (capture_idle),
        .win_begin    (win_begin),
        .win_end      (win_end),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_last      (rd_last),
        .rd_ready     (rd_ready),
`ifdef READBACK_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .req_count    (req_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every accepted request, plus hold-stable checks across stalls.
    always @(negedge clk) begin
        if (!reset && rd_req && rd_ready) begin
            check_val("xfer_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check_val("rd_addr", 64'(rd_addr), 64'(exp_e[7:0]));
                check_val("rd_last", 64'(rd_last), 64'(exp_e[8]));
            end
        end
        if (chk_hold && prev_stall) begin
            check_val("stall_rd_req", 64'(rd_req), 64'd1);
            check_val("stall_rd_addr", 64'(rd_addr), 64'(prev_addr));
            check_val("stall_rd_last", 64'(rd_last), 64'(prev_last));
        end
        prev_stall = rd_req && !rd_ready && !reset;
        prev_addr  = rd_addr;
        prev_last  = rd_last;
        if (done) done_cnt++;
    end

    task automatic push_window(input int b, input int e, output int nreq);
        int rem;
        rem = (e - b + DEPTH) % DEPTH;
        if (rem == 0) rem = DEPTH;
        nreq = (rem + BURST - 1) / BURST;
        for (int i = 0; i < nreq; i++)
            exp_q.push_back({(i == nreq - 1), 8'((b + i * BURST) % DEPTH)});
    endtask

    task automatic kick(input int b, input int e);
        @(posedge clk); #1;
        win_begin    = 8'(b);
        win_end      = 8'(e);
        capture_idle = 1'b1;
        start        = 1'b1;
        rd_ready     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        win_begin = 8'd40;
        win_end   = 8'd44;
    endtask

    task automatic run_window(input int b, input int e, input bit stall);
        int nreq;
        int cyc;
        bit got;
        bit [3:0] pat;
        pat = 4'b1001;
        push_window(b, e, nreq);
        kick(b, e);
        got = 1'b0;
        cyc = 1;
        while (!got && cyc < 400) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                @(posedge clk); #1;
                rd_ready = stall ? pat[cyc % 4] : 1'b1;
                start    = (stall && cyc == 3);
                cyc++;
            end
        end
        start = 1'b0;
        check_val("done_seen", 64'(got), 64'd1);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);
        check_val("req_count", 64'(req_count), 64'(nreq));
        check_val("done_busy", 64'(busy), 64'd1);
        check_val("done_rd_req", 64'(rd_req), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("idle_done", 64'(done), 64'd0);
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_rd_req", 64'(rd_req), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_xfers(input int want, input string tag);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < want && cyc < 50) begin
            @(negedge clk);
            if (rd_req && rd_ready) cnt++;
            cyc++;
        end
        check_val(tag, 64'(cnt), 64'(want));
    endtask

    initial begin
        int nreq;
        int d0;
        reset        = 1'b1;
        start        = 1'b0;
        capture_idle = 1'b0;
        win_begin    = '0;
        win_end      = '0;
        rd_ready     = 1'b0;
`ifdef READBACK_ABORT_EN
        abort        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_rd_req", 64'(rd_req), 64'd0);
        check_val("rst_rd_last", 64'(rd_last), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_rd_addr", 64'(rd_addr), 64'd0);
        check_val("rst_req_count", 64'(req_count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_window(8, 24, 1'b0);
        run_window(56, 8, 1'b0);
        run_window(16, 16, 1'b0);
        run_window(8, 24, 1'b1);
        run_window(10, 20, 1'b0);

        // start ignored while sampler is busy capturing
        @(posedge clk); #1;
        win_begin    = 8'd8;
        win_end      = 8'd24;
        capture_idle = 1'b0;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        capture_idle = 1'b1;
        repeat (2) @(negedge clk);
        check_val("noidle_busy", 64'(busy), 64'd0);
        check_val("noidle_rd_req", 64'(rd_req), 64'd0);

        // reset after the second accepted request
        push_window(8, 24, nreq);
        kick(8, 24);
        wait_xfers(2, "rst_wait_xfers");
        d0 = done_cnt;
        @(posedge clk); #1;
        reset    = 1'b1;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_rd_req", 64'(rd_req), 64'd0);
        check_val("midrst_req_count", 64'(req_count), 64'd0);
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_rd_addr", 64'(rd_addr), 64'd0);
        repeat (3) @(posedge clk);
        check_val("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        exp_q.delete();

`ifdef READBACK_ABORT_EN
        exp_q.push_back({1'b0, 8'd8});
        kick(8, 24);
        wait_xfers(1, "abort_wait_xfer");
        @(posedge clk); #1;
        chk_hold = 1'b0;
        abort    = 1'b1;
        rd_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_done", 64'(done), 64'd1);
        check_val("abort_req_count", 64'(req_count), 64'd1);
        check_val("abort_rd_req", 64'(rd_req), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("abort_after_rd_req", 64'(rd_req), 64'd0);
        check_val("abort_after_busy", 64'(busy), 64'd0);
        chk_hold = 1'b1;
        exp_q.delete();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
